decode_queue: RTL
=================

Name: decode_queue

Overview:
- Registered, parametrised successor to the combinational instruction decoder.
- Accepts fetched instructions with PC over a valid/ready handshake and decodes them fully at enqueue:
  - instruction type
  - register fields
  - correctly extended immediate
  - branch/jump target
  - illegal-instruction flag
- Buffers decoded bundles in a DEPTH-entry FIFO toward the execute stage.
- Sits between the fetch stage and issue/execute, and supports pipeline flush on redirect.

Parameters:
- W, 32, word width of instruction, PC, imm and targets (≥32; instruction fields always taken from bits [31:0]).
- DEPTH, 2, number of decoded-bundle entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  discard all buffered entries and the current input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept (= not full).
- in_inst  in  W  raw instruction.
- in_pc  in  W  PC of the instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_inst_type  out  2  00=R, 01=I, 10=J, 11 unused.
- out_op_code  out  6  inst[31:26].
- out_funct  out  6  inst[5:0] for R; 0 otherwise.
- out_rs, out_rt, out_rd  out  5 each  inst[25:21], inst[20:16], inst[15:11]; each 0 where not applicable to the type.
- out_shamt  out  5  inst[10:6] for R; 0 otherwise.
- out_imm  out  W  extended immediate.
- out_pc  out  W  PC of the entry.
- out_br_target  out  W  branch/jump target.
- out_illegal  out  1  unsupported opcode/funct.

Behaviour:
- Reset (rst=0, async):
  - FIFO pointers and count cleared; all stored entries zeroed.
  - out_valid=0 and all out_* fields read 0.
  - in_ready=1 once reset is released.
- Type classification:
  - op 000000 → R.
  - op 000010 (J) and 000011 (JAL) → J.
  - Everything else → I.
- Immediate rules:
  - R: funct SLL(000000)/SRL(000010)/SRA(000011) give imm = zext(shamt); otherwise 0.
  - I, sign-extend inst[15:0]: ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011, LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
  - I, zero-extend inst[15:0]: ANDI 001100, ORI 001101, XORI 001110.
  - LUI 001111: {inst[15:0], 16'b0}, sign-extended to W.
  - Branches BGEZ/BLTZ 000001, BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111: sext({inst[15:0], 2'b00}).
  - J-type: imm = zext({inst[25:0], 2'b00}).
- Target computation, with pc4 = in_pc + 4 (mod 2^W):
  - Branches: br_target = pc4 + imm.
  - J/JAL: br_target = {pc4[W-1:28], inst[25:0], 2'b00}.
  - Others: br_target = pc4.
- Illegal flag (out_illegal=1):
  - Any opcode not listed above.
  - R-type whose funct is not one of:
    - 000000, 000010, 000011, 000100, 000110, 000111
    - 001000 (JR), 001001 (JALR)
    - 100000–100111, 101010, 101011
  - An illegal entry still has its fields decoded per type and is enqueued normally.
- Handshake:
  - Push when in_valid & in_ready & !flush.
  - Pop when out_valid & out_ready & !flush.
  - in_ready = (count != DEPTH); it is combinational from state only, with no path from out_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, in_ready=0 and the input is held by fetch, even if a pop occurs in that same cycle.
- Latency:
  - An entry pushed at edge N is visible with out_valid=1 after edge N (1-cycle latency).
  - out_* fields are driven from the head register, so there is no combinational path from in_* to out_*.
- Pointers wrap modulo DEPTH; count spans 0..DEPTH.
- Output stability: while out_valid=1 & out_ready=0, all out_* fields hold stable.
- Flush:
  - At the next edge, count=0 and pointers=0; out_valid=0 after that edge.
  - The same-cycle input is dropped, and a same-cycle pop is not counted.
  - Flush takes priority over push/pop.
- Reset mid-operation: all state clears immediately (async); queue contents are lost.

Test Plan:
- ADDI 0x2008FFFF, pc 0x00400000, out_ready=1 → next cycle out_valid=1, type=01, op=0x08, rs=0, rt=8, imm=0xFFFFFFFF, br_target=0x00400004, illegal=0.
- BEQ 0x1000FFFF at pc 0x00400010 → imm=0xFFFFFFFC, br_target=0x00400010. J 0x08100004 at pc 0x00400020 → type=10, br_target=0x00400010.
- SLL 0x00084080 → type=00, rd=8, rt=8, shamt=2, funct=0, imm=0x00000002. ORI 0x3408FFFF → imm=0x0000FFFF. Opcode 0xFC000000 → illegal=1.
- Backpressure: out_ready=0, push 3 instructions with DEPTH=2 → in_ready falls after 2nd push, 3rd held. Raise out_ready → entries emerge in order, fields stable while stalled.
- Flush with 2 entries queued and in_valid=1 → out_valid=0 next cycle, in_ready=1, the flushed input is never output.
- Assert rst=0 asynchronously mid-stream with a full queue → out_valid=0 and out fields=0 immediately. After release, normal push resumes.

Source files
------------

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
//   Registered instruction decoder with a small FIFO of decoded bundles.
//   Fetched instructions are fully decoded when they are enqueued (type,
//   register fields, extended immediate, branch/jump target, illegal flag)
//   and handed to the execute stage from the head entry of the queue.
//
// Parameters
//   W      width of instruction, PC, immediate and target words (>= 32)
//   DEPTH  number of decoded-bundle entries (power of two, >= 2)
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   flush           drop all buffered entries and the current input
//   in_valid/ready  fetch-side handshake; in_ready = queue not full
//   in_inst, in_pc  raw instruction and its PC
//   out_valid/ready execute-side handshake for the head entry
//   out_*           decoded fields of the head entry
// ---------------------------------------------------------------------------
module decode_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_inst,
  input  logic [W-1:0] in_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_inst_type,
  output logic [5:0]   out_op_code,
  output logic [5:0]   out_funct,
  output logic [4:0]   out_rs,
  output logic [4:0]   out_rt,
  output logic [4:0]   out_rd,
  output logic [4:0]   out_shamt,
  output logic [W-1:0] out_imm,
  output logic [W-1:0] out_pc,
  output logic [W-1:0] out_br_target,
  output logic         out_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;

  typedef struct packed {
    logic [1:0]   inst_type;
    logic [5:0]   op_code;
    logic [5:0]   funct;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [4:0]   shamt;
    logic [W-1:0] imm;
    logic [W-1:0] pc;
    logic [W-1:0] br_target;
    logic         illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  logic [5:0]      op;
  logic [5:0]      fn;
  logic [W-1:0]    pc4;
  logic [W-1:0]    sext16;
  logic [W-1:0]    zext16;
  logic [W-1:0]    br_off;
  logic [W-1:0]    j_off;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Combinational decode of the incoming instruction; the result is only
  // ever observed after it has been written into the queue.
  always_comb begin
    op     = in_inst[31:26];
    fn     = in_inst[5:0];
    pc4    = in_pc + W'(4);
    sext16 = {{(W-16){in_inst[15]}}, in_inst[15:0]};
    zext16 = {{(W-16){1'b0}}, in_inst[15:0]};
    br_off = {{(W-18){in_inst[15]}}, in_inst[15:0], 2'b00};
    j_off  = {{(W-28){1'b0}}, in_inst[25:0], 2'b00};

    dec           = '0;
    dec.op_code   = op;
    dec.pc        = in_pc;
    dec.br_target = pc4;

    case (op)
      6'b000000: begin
        dec.inst_type = TYPE_R;
        dec.funct     = fn;
        dec.rs        = in_inst[25:21];
        dec.rt        = in_inst[20:16];
        dec.rd        = in_inst[15:11];
        dec.shamt     = in_inst[10:6];
        // Constant shifts carry their shift amount as the immediate.
        if (fn == 6'b000000 || fn == 6'b000010 || fn == 6'b000011)
          dec.imm = {{(W-5){1'b0}}, in_inst[10:6]};
        case (fn) inside
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
          6'b000111, 6'b001000, 6'b001001, [6'b100000:6'b100111],
          6'b101010, 6'b101011: dec.illegal = 1'b0;
          default:              dec.illegal = 1'b1;
        endcase
      end
      6'b000010, 6'b000011: begin
        dec.inst_type = TYPE_J;
        dec.imm       = j_off;
        // Jump target keeps the upper bits of the sequential PC.
        dec.br_target = {pc4[W-1:28], in_inst[25:0], 2'b00};
      end
      default: begin
        dec.inst_type = TYPE_I;
        dec.rs        = in_inst[25:21];
        dec.rt        = in_inst[20:16];
        case (op)
          6'b001000, 6'b001001, 6'b001010, 6'b001011,
          6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
          6'b101000, 6'b101001, 6'b101011:
            dec.imm = sext16;
          6'b001100, 6'b001101, 6'b001110:
            dec.imm = zext16;
          6'b001111:
            dec.imm = sext16 << 16;
          6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
            dec.imm       = br_off;
            dec.br_target = pc4 + br_off;
          end
          default:
            dec.illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Queue storage and pointers. Flush wins over any push or pop in the same
  // cycle; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs come straight from the head register, so nothing on the fetch
  // side can reach them combinationally.
  assign out_inst_type = mem[rd_ptr].inst_type;
  assign out_op_code   = mem[rd_ptr].op_code;
  assign out_funct     = mem[rd_ptr].funct;
  assign out_rs        = mem[rd_ptr].rs;
  assign out_rt        = mem[rd_ptr].rt;
  assign out_rd        = mem[rd_ptr].rd;
  assign out_shamt     = mem[rd_ptr].shamt;
  assign out_imm       = mem[rd_ptr].imm;
  assign out_pc        = mem[rd_ptr].pc;
  assign out_br_target = mem[rd_ptr].br_target;
  assign out_illegal   = mem[rd_ptr].illegal;

endmodule
